// File: rtl/grid_ram_arbiter.sv
// Owner of the snake grid RAM: arbitrates a read-only display port against a read/write
// game port and runs the new-game clear sweep. Define SNAKE_WALL_INIT_EN to paint border walls.
module grid_ram_arbiter #(
  parameter int             CW         = 4,
  parameter int             DW         = 4,
  parameter logic [DW-1:0]  CLR_VAL    = '0,
  parameter logic [DW-1:0]  WALL_VAL   = DW'(1),
  parameter int             STARVE_MAX = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr_start,
  output logic            o_clr_busy,
  input  logic            i_disp_req,
  input  logic [CW-1:0]   i_disp_x,
  input  logic [CW-1:0]   i_disp_y,
  output logic            o_disp_ack,
  output logic            o_disp_valid,
  output logic [DW-1:0]   o_disp_data,
  input  logic            i_game_req,
  input  logic            i_game_we,
  input  logic [CW-1:0]   i_game_x,
  input  logic [CW-1:0]   i_game_y,
  input  logic [DW-1:0]   i_game_wdata,
  output logic            o_game_ack,
  output logic            o_game_valid,
  output logic [DW-1:0]   o_game_rdata,
  output logic            o_ram_we,
  output logic [2*CW-1:0] o_ram_addr,
  output logic [DW-1:0]   o_ram_wdata,
  input  logic [DW-1:0]   i_ram_rdata,
  output logic            o_dbg_state
);

  localparam int AW = 2 * CW;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  // Handshake: a requester holds req and its address/data until ack; ack is combinational and
  // each cycle ack is high is one RAM access. Read data returns with a one-cycle valid pulse.
  state_t          r_state;
  logic [AW-1:0]   r_sweep;
  logic [SW-1:0]   r_starve;
  logic            r_clr_busy;
  logic            r_disp_valid;
  logic            r_game_valid;
  logic [DW-1:0]   r_disp_data;
  logic [DW-1:0]   r_game_rdata;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_arb_en;
  logic            w_game_win;
  logic            w_disp_ack;
  logic            w_game_ack;
  logic [CW-1:0]   w_sx;
  logic [CW-1:0]   w_sy;
  logic [DW-1:0]   w_sweep_val;

  assign w_sx = r_sweep[AW-1:CW];
  assign w_sy = r_sweep[CW-1:0];

`ifdef SNAKE_WALL_INIT_EN
  logic w_border;
  assign w_border = (w_sx == '0) || (w_sx == {CW{1'b1}}) ||
                    (w_sy == '0) || (w_sy == {CW{1'b1}});
  assign w_sweep_val = w_border ? WALL_VAL : CLR_VAL;
`else
  logic w_unused_wall;
  assign w_unused_wall = ^{WALL_VAL, w_sx, w_sy};
  assign w_sweep_val = CLR_VAL;
`endif

  // A clr_start cycle grants nobody, so the sweep owns the RAM from the very next cycle.
  assign w_arb_en   = (r_state == S_IDLE) && !i_clr_start && !i_rst;
  assign w_game_win = i_game_req && (!i_disp_req || (r_starve == SW'(STARVE_MAX)));
  assign w_game_ack = w_arb_en && w_game_win;
  assign w_disp_ack = w_arb_en && i_disp_req && !w_game_win;

  assign o_disp_ack   = w_disp_ack;
  assign o_game_ack   = w_game_ack;
  assign o_clr_busy   = r_clr_busy;
  assign o_disp_valid = r_disp_valid;
  assign o_game_valid = r_game_valid;
  assign o_dbg_state  = r_state;

  // The RAM output is live during the valid cycle; the registers keep it afterwards.
  assign o_disp_data  = r_disp_valid ? i_ram_rdata : r_disp_data;
  assign o_game_rdata = r_game_valid ? i_ram_rdata : r_game_rdata;

  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = r_addr;
    o_ram_wdata = r_wdata;
    if (r_state == S_CLEAR) begin
      o_ram_we    = 1'b1;
      o_ram_addr  = r_sweep;
      o_ram_wdata = w_sweep_val;
    end else if (w_game_ack) begin
      o_ram_we    = i_game_we;
      o_ram_addr  = {i_game_x, i_game_y};
      o_ram_wdata = i_game_wdata;
    end else if (w_disp_ack) begin
      o_ram_addr  = {i_disp_x, i_disp_y};
      o_ram_wdata = i_game_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sweep      <= '0;
      r_starve     <= '0;
      r_clr_busy   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_game_valid <= 1'b0;
      r_disp_data  <= '0;
      r_game_rdata <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_disp_valid <= w_disp_ack;
      r_game_valid <= w_game_ack && !i_game_we;
      r_addr       <= o_ram_addr;
      r_wdata      <= o_ram_wdata;
      if (r_disp_valid) r_disp_data  <= i_ram_rdata;
      if (r_game_valid) r_game_rdata <= i_ram_rdata;

      if (!i_game_req || w_game_ack)
        r_starve <= '0;
      else if (w_disp_ack && (r_starve != SW'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_clr_start) begin
            r_state    <= S_CLEAR;
            r_clr_busy <= 1'b1;
            r_sweep    <= '0;
          end
        end
        S_CLEAR: begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == {AW{1'b1}}) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Directed bench for grid_ram_arbiter with a behavioural 256x4 synchronous RAM.
// Build with +define+SNAKE_WALL_INIT_EN to check the walled clear sweep.
module tb_grid_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start, clr_busy;
  logic       disp_req, disp_ack, disp_valid;
  logic [3:0] disp_x, disp_y, disp_data;
  logic       game_req, game_we, game_ack, game_valid;
  logic [3:0] game_x, game_y, game_wdata, game_rdata;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata, ram_rdata;
  logic       dbg_state;

  logic [3:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grid_ram_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_clr_start(clr_start), .o_clr_busy(clr_busy),
    .i_disp_req(disp_req), .i_disp_x(disp_x), .i_disp_y(disp_y), .o_disp_ack(disp_ack),
    .o_disp_valid(disp_valid), .o_disp_data(disp_data),
    .i_game_req(game_req), .i_game_we(game_we), .i_game_x(game_x), .i_game_y(game_y),
    .i_game_wdata(game_wdata), .o_game_ack(game_ack), .o_game_valid(game_valid),
    .o_game_rdata(game_rdata), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [3:0] sweep_exp(input logic [7:0] a);
`ifdef SNAKE_WALL_INIT_EN
    if (a[7:4] == 4'h0 || a[7:4] == 4'hF || a[3:0] == 4'h0 || a[3:0] == 4'hF) return 4'd1;
`endif
    return 4'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] rb_addr [4];
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = 4'(i);
    rb_addr[0] = 8'h00; rb_addr[1] = 8'h0F; rb_addr[2] = 8'hF7; rb_addr[3] = 8'h55;

    // Reset with requests asserted: nothing may be granted or written.
    rst = 1'b1; clr_start = 1'b0;
    disp_req = 1'b1; disp_x = 4'h0; disp_y = 4'h0;
    game_req = 1'b1; game_we = 1'b1; game_x = 4'h0; game_y = 4'h0; game_wdata = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_disp_ack", 32'(disp_ack), 32'd0);
    check("rst_game_ack", 32'(game_ack), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_game_valid", 32'(game_valid), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_game_rdata", 32'(game_rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    disp_req = 1'b0; game_req = 1'b0; game_we = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Display read of (3,5); RAM was preloaded with the low address nibble.
    @(negedge clk);
    disp_req = 1'b1; disp_x = 4'h3; disp_y = 4'h5;
    #1;
    check("t1_disp_ack", 32'(disp_ack), 32'd1);
    check("t1_game_ack", 32'(game_ack), 32'd0);
    check("t1_addr", 32'(ram_addr), 32'h35);
    check("t1_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    disp_req = 1'b0;
    check("t1_valid", 32'(disp_valid), 32'd1);
    check("t1_data", 32'(disp_data), 32'd5);
    @(negedge clk);
    check("t1_valid_end", 32'(disp_valid), 32'd0);
    check("t1_data_hold", 32'(disp_data), 32'd5);

    // Game write then read of (2,7).
    game_req = 1'b1; game_we = 1'b1; game_x = 4'h2; game_y = 4'h7; game_wdata = 4'h3;
    #1;
    check("t2_wr_ack", 32'(game_ack), 32'd1);
    check("t2_wr_we", 32'(ram_we), 32'd1);
    check("t2_wr_addr", 32'(ram_addr), 32'h27);
    check("t2_wr_wdata", 32'(ram_wdata), 32'd3);
    @(negedge clk);
    check("t2_wr_novalid", 32'(game_valid), 32'd0);
    game_we = 1'b0;
    #1;
    check("t2_rd_ack", 32'(game_ack), 32'd1);
    check("t2_rd_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    game_req = 1'b0;
    check("t2_rd_valid", 32'(game_valid), 32'd1);
    check("t2_rd_data", 32'(game_rdata), 32'd3);
    @(negedge clk);
    check("t2_rd_valid_end", 32'(game_valid), 32'd0);

    // Both ports held: D,D,D,G repeating. Display (1,1) holds 1, game (2,7) holds 3.
    disp_x = 4'h1; disp_y = 4'h1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        check("t3_disp_valid", 32'(disp_valid), 32'((i - 1) % 4 != 3));
        check("t3_game_valid", 32'(game_valid), 32'((i - 1) % 4 == 3));
      end
      disp_req = 1'b1; game_req = 1'b1;
      #1;
      check("t3_game_ack", 32'(game_ack), 32'(i % 4 == 3));
      check("t3_disp_ack", 32'(disp_ack), 32'(i % 4 != 3));
      @(negedge clk);
    end
    disp_req = 1'b0; game_req = 1'b0;
    check("t3_last_valid", 32'(game_valid), 32'd1);
    check("t3_last_data", 32'(game_rdata), 32'd3);
    check("t3_disp_data", 32'(disp_data), 32'd1);

    // Clear sweep with both requests pending throughout.
    @(negedge clk);
    clr_start = 1'b1; disp_req = 1'b1; game_req = 1'b1;
    #1;
    check("t4_start_disp_ack", 32'(disp_ack), 32'd0);
    check("t4_start_game_ack", 32'(game_ack), 32'd0);
    check("t4_start_we", 32'(ram_we), 32'd0);
    for (int s = 0; s < 256; s++) begin
      @(negedge clk);
      clr_start = 1'b0;
      #1;
      check("t4_busy", 32'(clr_busy), 32'd1);
      check("t4_we", 32'(ram_we), 32'd1);
      check("t4_addr", 32'(ram_addr), 32'(s));
      check("t4_wdata", 32'(ram_wdata), 32'(sweep_exp(8'(s))));
      check("t4_no_ack", 32'({disp_ack, game_ack}), 32'd0);
    end
    @(negedge clk);
    #1;
    check("t4_busy_end", 32'(clr_busy), 32'd0);
    check("t4_resume_disp", 32'(disp_ack), 32'd1);
    check("t4_resume_game", 32'(game_ack), 32'd0);
    @(negedge clk);
    disp_req = 1'b0; game_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      disp_req = 1'b1; disp_x = rb_addr[k][7:4]; disp_y = rb_addr[k][3:0];
      @(negedge clk);
      disp_req = 1'b0;
      check("t4_readback", 32'(disp_data), 32'(sweep_exp(rb_addr[k])));
    end

    // A second clr_start during the sweep must not restart it.
    @(negedge clk);
    clr_start = 1'b1;
    for (int s = 0; s < 256; s++) begin
      @(negedge clk);
      clr_start = (s == 100);
      #1;
      check("t5_addr", 32'(ram_addr), 32'(s));
      check("t5_busy", 32'(clr_busy), 32'd1);
    end
    @(negedge clk);
    clr_start = 1'b0;
    #1;
    check("t5_busy_end", 32'(clr_busy), 32'd0);
    check("t5_we_end", 32'(ram_we), 32'd0);

    // Reset in the middle of a sweep aborts it immediately.
    @(negedge clk);
    clr_start = 1'b1;
    for (int s = 0; s <= 150; s++) begin
      @(negedge clk);
      clr_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("t5_rst_we", 32'(ram_we), 32'd0);
    check("t5_rst_busy", 32'(clr_busy), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read in flight as clr_start arrives: valid still pulses with the right data.
    @(negedge clk);
    game_req = 1'b1; game_we = 1'b1; game_x = 4'hA; game_y = 4'h9; game_wdata = 4'hC;
    #1;
    check("t6_wr_ack", 32'(game_ack), 32'd1);
    @(negedge clk);
    game_req = 1'b0; game_we = 1'b0;
    disp_req = 1'b1; disp_x = 4'hA; disp_y = 4'h9;
    #1;
    check("t6_disp_ack", 32'(disp_ack), 32'd1);
    @(negedge clk);
    clr_start = 1'b1;
    check("t6_valid", 32'(disp_valid), 32'd1);
    check("t6_data", 32'(disp_data), 32'hC);
    #1;
    check("t6_no_ack", 32'(disp_ack), 32'd0);
    check("t6_busy_pre", 32'(clr_busy), 32'd0);
    @(negedge clk);
    clr_start = 1'b0;
    check("t6_busy", 32'(clr_busy), 32'd1);
    check("t6_valid_end", 32'(disp_valid), 32'd0);
    check("t6_data_hold", 32'(disp_data), 32'hC);
    cnt = 0;
    while (clr_busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_sweep_len", 32'(cnt), 32'd256);
    #1;
    check("t6_pending_ack", 32'(disp_ack), 32'd1);
    @(negedge clk);
    disp_req = 1'b0;
    check("t6_after_valid", 32'(disp_valid), 32'd1);
    check("t6_after_data", 32'(disp_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
